// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
// Drives one 4-bit slice per clock into an external carry_skip_adder,
// least significant nibble first. The carry is chained through a register,
// and the full-width sum and carry-out are assembled from the slices.
// A start/busy/done handshake lets one small adder serve a wide add.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_c0,
  input  logic [3:0]           add_s,
  input  logic                 add_cout,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_part;
  logic [W-1:0]     r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IDX_W+1:0] w_bit;
  logic             w_last;

  // Bit offset of the active slice, and whether it is the top slice.
  assign w_bit  = {r_idx, 2'b00};
  assign w_last = (r_idx == LAST);

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and the combinational slice mux toward the adder.
  always_comb begin
    w_next = r_state;
    add_a  = 4'd0;
    add_b  = 4'd0;
    add_c0 = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = RUN;
        end
      end
      RUN: begin
        add_a  = r_a[w_bit +: 4];
        add_b  = r_b[w_bit +: 4];
        add_c0 = r_carry;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Operand capture; operands are free to change once accepted.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == IDLE) && start) begin
      r_a <= a;
      r_b <= b;
    end
  end

  // Slice index, carry chain, partial sum and the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_part  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_part[w_bit +: 4] <= add_s;
          r_carry            <= add_cout;
          if (w_last) begin
            // Top slice comes straight from the adder; lower slices are stored.
            r_idx  <= '0;
            r_sum  <= {add_s, r_part[W-5:0]};
            r_cout <= add_cout;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
